// File: rtl/game_pkg.sv
// Shared encodings and widths for the breakout game controller.
package game_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned LIVES_W          = 2;
    localparam int unsigned SCORE_W          = 8;
    localparam int unsigned SPEED_W          = 2;
    localparam int unsigned SERVE_CNT_W      = 8;
    localparam int unsigned SCORE_MAX        = (1 << SCORE_W) - 1;
    localparam int unsigned SPEED_MAX        = 3;
    localparam int unsigned SPEEDUP_INTERVAL = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WON   = 3'd5
    } state_t;

    // True when a score value lands on a speed-up boundary.
    function automatic logic speedup_due(input logic [SCORE_W-1:0] s);
        return (s % SCORE_W'(SPEEDUP_INTERVAL)) == '0;
    endfunction

endpackage

// File: rtl/game_edge_detect.sv
// Rising-edge detector for the serve button; a level already high when reset
// releases is not reported as an edge until it has been seen low.
module game_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise_c
);

    logic armed;  // level was low on the previous cycle

    always_ff @(posedge clock or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= ~level;
    end

    assign rise_c = level & armed;

endmodule

// File: rtl/game_controller.sv
// Breakout game sequencing: serve, play, lives and score bookkeeping.
// Optional ball speed-up every 8 bricks is enabled by defining BALL_SPEEDUP_EN.
module game_controller
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned BRICK_COUNT  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frameTick,
    input  logic               launch,
    input  logic               ballMissed,
    input  logic               brickHit,
    output logic               ballEnable,
    output logic               ballReload,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [SPEED_W-1:0] speed,
    output logic               gameOver,
    output logic               gameWon,
    output logic [STATE_W-1:0] state
);

    state_t                   cur_state;
    state_t                   nxt_state;
    logic                     launch_evt;
    logic                     start_game;
    logic                     count_brick;
    logic                     lose_life;
    logic                     serve_done;
    logic [SCORE_W-1:0]       score_inc;
    logic [SERVE_CNT_W-1:0]   serve_cnt;

    game_edge_detect u_launch_edge (
        .clock  (clock),
        .reset  (reset),
        .level  (launch),
        .rise_c (launch_evt)
    );

    assign score_inc  = (score == SCORE_W'(SCORE_MAX)) ? score : score + SCORE_W'(1);
    // The entry cycle (ballReload high) never counts a frame tick.
    assign serve_done = frameTick && !ballReload &&
                        (serve_cnt == SERVE_CNT_W'(SERVE_FRAMES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur_state <= ST_IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state   = cur_state;
        start_game  = 1'b0;
        count_brick = 1'b0;
        lose_life   = 1'b0;
        case (cur_state)
            ST_IDLE, ST_OVER, ST_WON: begin
                if (launch_evt) begin
                    start_game = 1'b1;
                    nxt_state  = ST_SERVE;
                end
            end
            ST_WAIT: begin
                if (launch_evt) nxt_state = ST_SERVE;
            end
            ST_SERVE: begin
                if (serve_done) nxt_state = ST_PLAY;
            end
            ST_PLAY: begin
                count_brick = brickHit;
                // A winning brick masks a simultaneous miss.
                if (brickHit && (score_inc == SCORE_W'(BRICK_COUNT))) begin
                    nxt_state = ST_WON;
                end else if (ballMissed) begin
                    lose_life = 1'b1;
                    nxt_state = (lives == LIVES_W'(1)) ? ST_OVER : ST_WAIT;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ballEnable = (cur_state == ST_PLAY);
        gameOver   = (cur_state == ST_OVER);
        gameWon    = (cur_state == ST_WON);
        state      = cur_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lives      <= LIVES_W'(LIVES_INIT);
            score      <= '0;
            serve_cnt  <= '0;
            ballReload <= 1'b0;
        end else begin
            ballReload <= (nxt_state == ST_SERVE) && (cur_state != ST_SERVE);
            if (start_game) begin
                lives <= LIVES_W'(LIVES_INIT);
                score <= '0;
            end else begin
                if (count_brick) score <= score_inc;
                if (lose_life && (lives != '0)) lives <= lives - LIVES_W'(1);
            end
            if ((cur_state != ST_SERVE) || ballReload) serve_cnt <= '0;
            else if (frameTick)                        serve_cnt <= serve_cnt + SERVE_CNT_W'(1);
        end
    end

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            speed <= SPEED_W'(1);
        end else if (start_game) begin
            speed <= SPEED_W'(1);
        end else if (count_brick && (score != SCORE_W'(SCORE_MAX)) && speedup_due(score_inc)
                     && (speed != SPEED_W'(SPEED_MAX))) begin
            speed <= speed + SPEED_W'(1);
        end
    end
`else
    assign speed = SPEED_W'(1);
`endif

endmodule

// File: tb/tb_game_controller.sv
// Randomized bench for game_controller: two instances (default and a short
// 4-brick game) share stimulus and are compared each cycle to a rule model.
module tb_game_controller;
    import game_pkg::*;

    localparam int LI   = 3;
    localparam int SF_A = 60;
    localparam int BC_A = 32;
    localparam int SF_B = 3;
    localparam int BC_B = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_WAIT  = 3;
    localparam int M_OVER  = 4;
    localparam int M_WON   = 5;

    logic clock = 1'b0;
    logic reset, frameTick, launch, ballMissed, brickHit;

    logic       a_ballEnable, a_ballReload, a_gameOver, a_gameWon;
    logic [1:0] a_lives, a_speed;
    logic [7:0] a_score;
    logic [2:0] a_state;
    logic       b_ballEnable, b_ballReload, b_gameOver, b_gameWon;
    logic [1:0] b_lives, b_speed;
    logic [7:0] b_score;
    logic [2:0] b_state;

    game_controller #(.LIVES_INIT(LI), .SERVE_FRAMES(SF_A), .BRICK_COUNT(BC_A)) dut_a (
        .clock(clock), .reset(reset), .frameTick(frameTick), .launch(launch),
        .ballMissed(ballMissed), .brickHit(brickHit), .ballEnable(a_ballEnable),
        .ballReload(a_ballReload), .lives(a_lives), .score(a_score), .speed(a_speed),
        .gameOver(a_gameOver), .gameWon(a_gameWon), .state(a_state)
    );

    game_controller #(.LIVES_INIT(LI), .SERVE_FRAMES(SF_B), .BRICK_COUNT(BC_B)) dut_b (
        .clock(clock), .reset(reset), .frameTick(frameTick), .launch(launch),
        .ballMissed(ballMissed), .brickHit(brickHit), .ballEnable(b_ballEnable),
        .ballReload(b_ballReload), .lives(b_lives), .score(b_score), .speed(b_speed),
        .gameOver(b_gameOver), .gameWon(b_gameWon), .state(b_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int mode;
        int lives;
        int score;
        int speed;
        int frames;
        bit reload;
        bit armed;
    } mdl_t;

    mdl_t ma, mb;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [7:0] mode_code(input int m);
        case (m)
            M_SERVE: return 8'(ST_SERVE);
            M_PLAY:  return 8'(ST_PLAY);
            M_WAIT:  return 8'(ST_WAIT);
            M_OVER:  return 8'(ST_OVER);
            M_WON:   return 8'(ST_WON);
            default: return 8'(ST_IDLE);
        endcase
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = M_IDLE; m.lives = LI; m.score = 0; m.speed = 1;
        m.frames = 0; m.reload = 1'b0; m.armed = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t mi, input int bc, input int sf,
                                      input bit l, input bit ft, input bit bm, input bit bh);
        mdl_t m;
        bit   ev;
        bit   first;
        m     = mi;
        ev    = l && m.armed;
        first = m.reload;
        m.armed  = !l;
        m.reload = 1'b0;
        case (m.mode)
            M_IDLE, M_OVER, M_WON: if (ev) begin
                m.lives = LI; m.score = 0; m.speed = 1;
                m.mode = M_SERVE; m.frames = 0; m.reload = 1'b1;
            end
            M_WAIT: if (ev) begin
                m.mode = M_SERVE; m.frames = 0; m.reload = 1'b1;
            end
            M_SERVE: if (ft && !first) begin
                m.frames++;
                if (m.frames == sf) m.mode = M_PLAY;
            end
            M_PLAY: begin
                if (bh && m.score < 255) begin
                    m.score++;
`ifdef BALL_SPEEDUP_EN
                    if (m.score % 8 == 0 && m.speed < 3) m.speed++;
`endif
                    if (m.score == bc) m.mode = M_WON;
                end
                if (m.mode == M_PLAY && bm) begin
                    if (m.lives <= 1) begin
                        m.lives = 0; m.mode = M_OVER;
                    end else begin
                        m.lives--; m.mode = M_WAIT;
                    end
                end
            end
            default: ;
        endcase
        return m;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("a.state",  8'(a_state),      mode_code(ma.mode));
        check("a.lives",  8'(a_lives),      8'(ma.lives));
        check("a.score",  a_score,          8'(ma.score));
        check("a.speed",  8'(a_speed),      8'(ma.speed));
        check("a.enable", 8'(a_ballEnable), 8'(ma.mode == M_PLAY));
        check("a.reload", 8'(a_ballReload), 8'(ma.reload));
        check("a.over",   8'(a_gameOver),   8'(ma.mode == M_OVER));
        check("a.won",    8'(a_gameWon),    8'(ma.mode == M_WON));
        check("b.state",  8'(b_state),      mode_code(mb.mode));
        check("b.lives",  8'(b_lives),      8'(mb.lives));
        check("b.score",  b_score,          8'(mb.score));
        check("b.speed",  8'(b_speed),      8'(mb.speed));
        check("b.enable", 8'(b_ballEnable), 8'(mb.mode == M_PLAY));
        check("b.reload", 8'(b_ballReload), 8'(mb.reload));
        check("b.over",   8'(b_gameOver),   8'(mb.mode == M_OVER));
        check("b.won",    8'(b_gameWon),    8'(mb.mode == M_WON));
    endtask

    task automatic step(input bit l, input bit ft, input bit bm, input bit bh);
        launch = l; frameTick = ft; ballMissed = bm; brickHit = bh;
        @(posedge clock);
        if (reset) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, BC_A, SF_A, l, ft, bm, bh);
            mb = mdl_step(mb, BC_B, SF_B, l, ft, bm, bh);
        end
        #1;
        check_all();
    endtask

    // Mid-cycle reset: outputs must clear before any clock edge.
    task automatic pulse_reset(input bit l);
        launch = l;
        reset  = 1'b1;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        check_all();
        step(l, 1'b1, 1'b1, 1'b1);
        step(l, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic serve_ticks();
        repeat (SF_A) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit lq;
        reset = 1'b0; launch = 1'b0; frameTick = 1'b0; ballMissed = 1'b0; brickHit = 1'b0;
        #1;
        pulse_reset(1'b0);

        // Serve with a tick in the entry cycle, then play through to a win on b.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        serve_ticks();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Lose lives on a until game over.
        repeat (2) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            serve_ticks();
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Fresh game on a with a long brick run for the speed-up steps.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        serve_ticks();
        repeat (26) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during serve with launch held through release.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        pulse_reset(1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);

        lq = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1999) == 0) pulse_reset(lq);
            if ($urandom_range(0, 5) == 0) lq = !lq;
            step(lq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
